// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - two-stage grouped carry-lookahead adder/subtractor with valid/ready flow control
// Optional macro CLA_SAT_EN: clamp the WIDTH-bit result to the signed limit on overflow.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);
  localparam int NG = WIDTH / GROUP;

  logic [WIDTH-1:0] b_eff, p_in, g_in;
  logic             cin_eff;
  logic [NG-1:0]    gp_in, gg_in;

  always_comb begin : cond_comb
    logic gacc;
    b_eff   = sub ? ~b : b;
    cin_eff = sub | c_in;
    p_in    = a ^ b_eff;
    g_in    = a & b_eff;
    gp_in   = '0;
    gg_in   = '0;
    for (int j = 0; j < NG; j++) begin
      gp_in[j] = &p_in[j*GROUP +: GROUP];
      gacc = 1'b0;
      for (int i = 0; i < GROUP; i++)
        gacc = g_in[j*GROUP+i] | (p_in[j*GROUP+i] & gacc);
      gg_in[j] = gacc;
    end
  end

  logic             v1, v2, ld2;
  logic [WIDTH-1:0] p1, g1;
  logic [NG-1:0]    gp1, gg1;
  logic             cin1, am1, bm1;

  // in_ready depends only on registered valids and out_ready, never on in_valid
  assign ld2       = !v2 || out_ready;
  assign in_ready  = !v1 || ld2;
  assign out_valid = v2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      p1   <= '0;
      g1   <= '0;
      gp1  <= '0;
      gg1  <= '0;
      cin1 <= 1'b0;
      am1  <= 1'b0;
      bm1  <= 1'b0;
    end else if (in_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        p1   <= p_in;
        g1   <= g_in;
        gp1  <= gp_in;
        gg1  <= gg_in;
        cin1 <= cin_eff;
        am1  <= a[WIDTH-1];
        bm1  <= b_eff[WIDTH-1];
      end
    end
  end

  logic [NG:0]    cg;
  logic [WIDTH:0] c, sum_n, sum_sat;
  logic           ovf_n;

  always_comb begin : carry_comb
    logic cc;
    cg[0] = cin1;
    for (int j = 0; j < NG; j++)
      cg[j+1] = gg1[j] | (gp1[j] & cg[j]);
    c = '0;
    // in-group carries restart from each group's lookahead carry-in
    for (int j = 0; j < NG; j++) begin
      cc = cg[j];
      for (int i = 0; i < GROUP; i++) begin
        c[j*GROUP+i] = cc;
        cc = g1[j*GROUP+i] | (p1[j*GROUP+i] & cc);
      end
    end
    c[WIDTH] = cg[NG];
    sum_n    = {1'b0, p1} ^ c;
    ovf_n    = (am1 == bm1) && (sum_n[WIDTH-1] != am1);
    sum_sat  = sum_n;
`ifdef CLA_SAT_EN
    if (ovf_n)
      sum_sat[WIDTH-1:0] = am1 ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    sum_sat = sum_n;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2  <= 1'b0;
      sum <= '0;
      ovf <= 1'b0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        sum <= sum_sat;
        ovf <= ovf_n;
      end
    end
  end
endmodule
